// File: rtl/fpu_pkg.sv
// Shared FPU control encodings and issue-controller state type.
package fpu_pkg;

  localparam logic [3:0] FC_ADD  = 4'd0;
  localparam logic [3:0] FC_SUB  = 4'd1;
  localparam logic [3:0] FC_MUL  = 4'd2;
  localparam logic [3:0] FC_DIV  = 4'd3;
  localparam logic [3:0] FC_SQRT = 4'd4;
  localparam logic [3:0] FC_FTOI = 4'd5;
  localparam logic [3:0] FC_FEQ  = 4'd6;
  localparam logic [3:0] FC_FLT  = 4'd7;
  localparam logic [3:0] FC_FLE  = 4'd8;
  localparam logic [3:0] FC_ITOF = 4'd9;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } fpu_state_t;

  // Codes above FC_ITOF have no unit behind them; their result reads as zero.
  function automatic logic fc_valid(input logic [3:0] fc);
    return (fc <= FC_ITOF);
  endfunction

endpackage

// File: rtl/fpu_issue_if.sv
// Decoder/unit-facing handshake and operand bundle of the FPU issue controller.
interface fpu_issue_if;
  logic        start;
  logic        flush;
  logic [3:0]  fpucontrol;
  logic        fpusrca;
  logic        mode;
  logic [31:0] fsrca;
  logic [31:0] fsrcb;
  logic [31:0] isrc;
  logic [31:0] unitres;
  logic [31:0] opx;
  logic [31:0] opy;
  logic [3:0]  ctl_q;
  logic        mode_q;
  logic [31:0] result;
  logic        done;
  logic        stall;

  modport master (
    output start, flush, fpucontrol, fpusrca, mode, fsrca, fsrcb, isrc, unitres,
    input  opx, opy, ctl_q, mode_q, result, done, stall
  );

  modport slave (
    input  start, flush, fpucontrol, fpusrca, mode, fsrca, fsrcb, isrc, unitres,
    output opx, opy, ctl_q, mode_q, result, done, stall
  );
endinterface

// File: rtl/fpu_lat.sv
// Op-code to latency lookup; unassigned codes take a single cycle.
module fpu_lat
  import fpu_pkg::*;
#(
  parameter int LAT_ADD  = 2,
  parameter int LAT_MUL  = 2,
  parameter int LAT_DIV  = 8,
  parameter int LAT_SQRT = 8,
  parameter int LAT_CVT  = 1,
  parameter int LAT_CMP  = 1
) (
  input  logic [3:0] fpucontrol,
  output logic [3:0] lat
);

  // The 4-bit down-counter cannot represent latencies outside 1..15.
  if (LAT_ADD  < 1 || LAT_ADD  > 15) begin : g_bad_add  $error("LAT_ADD out of range");  end
  if (LAT_MUL  < 1 || LAT_MUL  > 15) begin : g_bad_mul  $error("LAT_MUL out of range");  end
  if (LAT_DIV  < 1 || LAT_DIV  > 15) begin : g_bad_div  $error("LAT_DIV out of range");  end
  if (LAT_SQRT < 1 || LAT_SQRT > 15) begin : g_bad_sqrt $error("LAT_SQRT out of range"); end
  if (LAT_CVT  < 1 || LAT_CVT  > 15) begin : g_bad_cvt  $error("LAT_CVT out of range");  end
  if (LAT_CMP  < 1 || LAT_CMP  > 15) begin : g_bad_cmp  $error("LAT_CMP out of range");  end

  // Latency per op class.
  always_comb begin
    lat = 4'd1;
    case (fpucontrol)
      FC_ADD, FC_SUB:          lat = 4'(LAT_ADD);
      FC_MUL:                  lat = 4'(LAT_MUL);
      FC_DIV:                  lat = 4'(LAT_DIV);
      FC_SQRT:                 lat = 4'(LAT_SQRT);
      FC_FTOI, FC_ITOF:        lat = 4'(LAT_CVT);
      FC_FEQ, FC_FLT, FC_FLE:  lat = 4'(LAT_CMP);
      default:                 lat = 4'd1;
    endcase
  end

endmodule

// File: rtl/fpu_issue.sv
// FPU issue controller: holds operands for the op latency, stalls, then
// returns the captured unit result with a one-cycle done pulse.
module fpu_issue
  import fpu_pkg::*;
#(
  parameter int LAT_ADD  = 2,
  parameter int LAT_MUL  = 2,
  parameter int LAT_DIV  = 8,
  parameter int LAT_SQRT = 8,
  parameter int LAT_CVT  = 1,
  parameter int LAT_CMP  = 1
) (
  input logic        clk,
  input logic        reset,
  fpu_issue_if.slave bus
);

  fpu_state_t  state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [31:0] opx_q, opx_d;
  logic [31:0] opy_q, opy_d;
  logic [3:0]  ctl_q, ctl_d;
  logic        mode_q, mode_d;
  logic [31:0] result_q, result_d;
  logic        done_q, done_d;
  logic        stall;
  logic [3:0]  lat;

  fpu_lat #(
    .LAT_ADD (LAT_ADD),
    .LAT_MUL (LAT_MUL),
    .LAT_DIV (LAT_DIV),
    .LAT_SQRT(LAT_SQRT),
    .LAT_CVT (LAT_CVT),
    .LAT_CMP (LAT_CMP)
  ) u_lat (
    .fpucontrol(bus.fpucontrol),
    .lat       (lat)
  );

  // Next-state, operand capture and stall decode.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    opx_d    = opx_q;
    opy_d    = opy_q;
    ctl_d    = ctl_q;
    mode_d   = mode_q;
    result_d = result_q;
    done_d   = 1'b0;
    stall    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        stall = bus.start;
        if (bus.start && !bus.flush) begin
          opx_d   = bus.fpusrca ? bus.isrc : bus.fsrca;
          opy_d   = bus.fsrcb;
          ctl_d   = bus.fpucontrol;
          mode_d  = bus.mode;
          cnt_d   = lat - 4'd1;
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        stall = 1'b1;
        if (bus.flush) begin
          state_d = ST_IDLE;
        end else if (cnt_q == 4'd0) begin
          result_d = fc_valid(ctl_q) ? bus.unitres : 32'd0;
          done_d   = 1'b1;
          state_d  = ST_DONE;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      // start seen here belongs to the retiring instruction, so it is ignored.
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      cnt_q    <= 4'd0;
      opx_q    <= 32'd0;
      opy_q    <= 32'd0;
      ctl_q    <= 4'd0;
      mode_q   <= 1'b0;
      result_q <= 32'd0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      opx_q    <= opx_d;
      opy_q    <= opy_d;
      ctl_q    <= ctl_d;
      mode_q   <= mode_d;
      result_q <= result_d;
      done_q   <= done_d;
    end
  end

  assign bus.opx    = opx_q;
  assign bus.opy    = opy_q;
  assign bus.ctl_q  = ctl_q;
  assign bus.mode_q = mode_q;
  assign bus.result = result_q;
  assign bus.done   = done_q;
  assign bus.stall  = stall;

endmodule

// File: tb/tb_fpu_issue.sv
// Directed bench for fpu_issue with default latencies.
module tb_fpu_issue;
  import fpu_pkg::*;

  logic clk = 1'b0;
  logic reset;
  int   n_vec = 0;
  int   n_err = 0;

  fpu_issue_if ifc ();

  fpu_issue dut (
    .clk  (clk),
    .reset(reset),
    .bus  (ifc)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: actual=%h required=%h", tag, obs, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  // Issue one op with start pulsed for cycle 0 only; unit model presents
  // res in cycle L and junk before. Source inputs are scrambled after
  // acceptance to prove the registered operands hold.
  task automatic run_op(input string tag, input logic [3:0] fc, input logic sel,
                        input logic md, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] i, input logic [31:0] res, input int lat,
                        input logic [31:0] exp_x, input logic [31:0] exp_res);
    ifc.fpucontrol = fc;
    ifc.fpusrca    = sel;
    ifc.mode       = md;
    ifc.fsrca      = a;
    ifc.fsrcb      = b;
    ifc.isrc       = i;
    ifc.unitres    = 32'hBAD0BAD0;
    ifc.start      = 1'b1;
    for (int c = 0; c <= lat + 1; c++) begin
      if (c == 1) begin
        ifc.start      = 1'b0;
        ifc.fsrca      = 32'h11111111;
        ifc.fsrcb      = 32'h22222222;
        ifc.isrc       = 32'h33333333;
        ifc.fpucontrol = 4'd15;
        ifc.mode       = ~md;
      end
      ifc.unitres = (c == lat) ? res : 32'hBAD0BAD0;
      #1;
      check($sformatf("%s stall c%0d", tag, c), {31'd0, ifc.stall}, (c <= lat) ? 32'd1 : 32'd0);
      check($sformatf("%s done c%0d", tag, c), {31'd0, ifc.done}, (c == lat + 1) ? 32'd1 : 32'd0);
      if (c >= 1) begin
        check($sformatf("%s opx c%0d", tag, c), ifc.opx, exp_x);
        check($sformatf("%s opy c%0d", tag, c), ifc.opy, b);
        check($sformatf("%s ctl c%0d", tag, c), {28'd0, ifc.ctl_q}, {28'd0, fc});
        check($sformatf("%s mode c%0d", tag, c), {31'd0, ifc.mode_q}, {31'd0, md});
      end
      if (c == lat + 1) check({tag, " result"}, ifc.result, exp_res);
      next_cycle();
    end
    #1;
    check({tag, " done after"}, {31'd0, ifc.done}, 32'd0);
    check({tag, " idle stall"}, {31'd0, ifc.stall}, 32'd0);
  endtask

  initial begin
    int dones;
    logic [31:0] res_before;
    ifc.start = 0; ifc.flush = 0; ifc.fpucontrol = 0; ifc.fpusrca = 0; ifc.mode = 0;
    ifc.fsrca = 0; ifc.fsrcb = 0; ifc.isrc = 0; ifc.unitres = 0;
    reset = 1'b1;
    next_cycle();
    next_cycle();
    ifc.start = 1'b1;
    #1;
    check("rst stall follows start", {31'd0, ifc.stall}, 32'd1);
    check("rst opx", ifc.opx, 32'd0);
    check("rst opy", ifc.opy, 32'd0);
    check("rst result", ifc.result, 32'd0);
    check("rst ctl/mode/done", {26'd0, ifc.ctl_q, ifc.mode_q, ifc.done}, 32'd0);
    ifc.start = 1'b0;
    #1;
    check("rst stall low", {31'd0, ifc.stall}, 32'd0);
    reset = 1'b0;
    next_cycle();

    run_op("fadd", FC_ADD, 0, 0, 32'h3F800000, 32'h40000000, 32'h0, 32'h40400000, 2,
           32'h3F800000, 32'h40400000);
    run_op("fdiv", FC_DIV, 0, 0, 32'h40C00000, 32'h40000000, 32'h0, 32'h40400000, 8,
           32'h40C00000, 32'h40400000);
    run_op("itof", FC_ITOF, 1, 0, 32'hDEADBEEF, 32'h0, 32'd5, 32'h40A00000, 1,
           32'd5, 32'h40A00000);
    run_op("ftoi", FC_FTOI, 0, 1, 32'h40E00000, 32'h0, 32'h0, 32'd7, 1,
           32'h40E00000, 32'd7);
    run_op("fc12", 4'd12, 0, 0, 32'hCAFEF00D, 32'h1234, 32'h0, 32'h12345678, 1,
           32'hCAFEF00D, 32'd0);

    // Back-to-back FEQ with start held: accepts at cycles 0 and 3.
    ifc.fpucontrol = FC_FEQ; ifc.fpusrca = 0; ifc.mode = 0;
    ifc.fsrca = 32'h3F800000; ifc.fsrcb = 32'h3F800000;
    ifc.start = 1'b1;
    dones = 0;
    for (int c = 0; c < 8; c++) begin
      if (c == 6) ifc.start = 1'b0;
      ifc.unitres = (c < 3) ? 32'd1 : 32'd0;
      if (c == 3) ifc.fsrca = 32'h40000000;
      #1;
      if (ifc.done) dones++;
      check($sformatf("b2b stall c%0d", c), {31'd0, ifc.stall},
            (c == 0 || c == 1 || c == 3 || c == 4) ? 32'd1 : 32'd0);
      check($sformatf("b2b done c%0d", c), {31'd0, ifc.done}, (c == 2 || c == 5) ? 32'd1 : 32'd0);
      if (c == 2) check("b2b result1", ifc.result, 32'd1);
      if (c == 4) check("b2b opx2", ifc.opx, 32'h40000000);
      if (c == 5) check("b2b result2", ifc.result, 32'd0);
      next_cycle();
    end
    check("b2b done count", dones, 32'd2);

    // flush in IDLE suppresses acceptance.
    ifc.fpucontrol = FC_MUL; ifc.fsrca = 32'h55555555;
    ifc.start = 1'b1; ifc.flush = 1'b1;
    next_cycle();
    ifc.start = 1'b0; ifc.flush = 1'b0;
    #1;
    check("idle flush no run", {31'd0, ifc.stall}, 32'd0);
    check("idle flush opx held", ifc.opx, 32'h40000000);
    next_cycle();

    // flush in RUN cycle 3 of FSQRT.
    res_before = ifc.result;
    ifc.fpucontrol = FC_SQRT; ifc.fsrca = 32'h41100000; ifc.fsrcb = 32'h0;
    ifc.unitres = 32'h40400000;
    ifc.start = 1'b1;
    dones = 0;
    for (int c = 0; c < 12; c++) begin
      if (c == 1) ifc.start = 1'b0;
      ifc.flush = (c == 3);
      #1;
      if (ifc.done) dones++;
      if (c == 4) check("flush idle stall", {31'd0, ifc.stall}, 32'd0);
      next_cycle();
    end
    ifc.flush = 1'b0;
    check("flush no done", dones, 32'd0);
    check("flush result held", ifc.result, res_before);

    // Same sequence with reset mid-RUN: async clear.
    ifc.start = 1'b1;
    for (int c = 0; c < 3; c++) begin
      if (c == 1) ifc.start = 1'b0;
      next_cycle();
    end
    #2;
    reset = 1'b1;
    #1;
    check("arst opx", ifc.opx, 32'd0);
    check("arst opy/ctl", {ifc.opy[27:0], ifc.ctl_q}, 32'd0);
    check("arst result", ifc.result, 32'd0);
    check("arst stall/done/mode", {29'd0, ifc.stall, ifc.done, ifc.mode_q}, 32'd0);
    next_cycle();
    reset = 1'b0;
    dones = 0;
    for (int c = 0; c < 10; c++) begin
      if (ifc.done) dones++;
      next_cycle();
    end
    check("arst no done", dones, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
